// File: rtl/zbus_if.sv
// Source-to-sink transfer bus: valid, payload and acknowledge.
interface zbus_if #(
    parameter int unsigned BW = 8
) ();
    logic          z_vld;
    logic [BW-1:0] z_bus;
    logic          z_ack;

    modport master (output z_vld, output z_bus, input z_ack);
    modport slave  (input z_vld, input z_bus, output z_ack);
endinterface

// File: rtl/zbus_source.sv
// Queued bus source: buffers loaded words and presents them one at a time on
// a valid/ack bus, with a programmable number of idle cycles after each transfer.
module zbus_source #(
    parameter int unsigned BW    = 8,
    parameter logic        XZ    = 1'bx,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic          z_clk,
    input  logic          z_rst,
    input  logic          ld_vld,
    input  logic [BW-1:0] ld_dat,
    output logic          ld_rdy,
    input  logic [7:0]    idle,
    output logic [CW-1:0] cnt,
    output logic          empty,
    zbus_if.master        zb
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t        r_state;
    logic [BW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;
    logic [7:0]    r_gap;
    logic [CW-1:0] r_cnt;
    logic          r_vld;
    logic [BW-1:0] r_bus;
    logic          r_empty;
    logic          r_ld_rdy;

    logic          w_push;
    logic          w_trn;
    logic [OW-1:0] w_occ_nxt;
    logic [OW-1:0] w_occ_left;
    logic [AW-1:0] w_rd_nxt;
    logic [BW-1:0] w_head_nxt;
    logic          w_has;
    logic [BW-1:0] w_fill;

    // Post-edge queue view; the head bypasses from ld_dat when the load lands in an empty slot
    always_comb begin
        w_push     = z_rst & ld_vld & r_ld_rdy;
        w_trn      = r_vld & zb.z_ack;
        w_occ_left = r_occ - OW'(w_trn);
        w_occ_nxt  = w_occ_left + OW'(w_push);
        w_rd_nxt   = r_rd_ptr + AW'(w_trn);
        w_head_nxt = (w_occ_left == '0) ? ld_dat : r_mem[w_rd_nxt];
        w_has      = (w_occ_nxt != '0);
        w_fill     = {BW{XZ}};
    end

    always_ff @(posedge z_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ld_dat;
        end
    end

    always_ff @(posedge z_clk) begin
        if (!z_rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_gap    <= '0;
            r_cnt    <= '0;
            r_vld    <= 1'b0;
            r_bus    <= w_fill;
            r_empty  <= 1'b1;
            r_ld_rdy <= 1'b1;
        end else begin
            r_occ    <= w_occ_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_empty  <= !w_has;
            r_ld_rdy <= (w_occ_nxt != OW'(DEPTH));
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_trn) begin
                r_cnt <= r_cnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_has) begin
                        r_state <= S_SEND;
                        r_vld   <= 1'b1;
                        r_bus   <= w_head_nxt;
                    end
                end
                S_SEND: begin
                    // Word is held until acknowledged; idle is latched only at the transfer
                    if (w_trn) begin
                        r_gap <= idle;
                        if (idle != 8'd0) begin
                            r_state <= S_GAP;
                            r_vld   <= 1'b0;
                            r_bus   <= w_fill;
                        end else if (w_has) begin
                            r_bus <= w_head_nxt;
                        end else begin
                            r_state <= S_IDLE;
                            r_vld   <= 1'b0;
                            r_bus   <= w_fill;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 8'd1;
                    if (r_gap <= 8'd1) begin
                        if (w_has) begin
                            r_state <= S_SEND;
                            r_vld   <= 1'b1;
                            r_bus   <= w_head_nxt;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_vld   <= 1'b0;
                    r_bus   <= w_fill;
                end
            endcase
        end
    end

    assign zb.z_vld = r_vld;
    assign zb.z_bus = r_bus;
    assign ld_rdy   = r_ld_rdy;
    assign cnt      = r_cnt;
    assign empty    = r_empty;
endmodule
